// File: rtl/serial_all_bits_set_rx.sv
// serial_all_bits_set_rx: assembles an MSB-first bit stream into words and reports
// an all-ones flag and popcount for each word on a valid/ready output port.
module serial_all_bits_set_rx #(
    parameter int DATA_W = 8,
    localparam int CNT_W = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              all_set,
    output logic [CNT_W-1:0]  set_count
);
    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;
    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] r_out_data;
    logic              r_all_set;
    logic [CNT_W-1:0]  r_set_count;
    logic [DATA_W-1:0] w_word;
    logic [CNT_W-1:0]  w_pop;
    logic              w_bit_xfer;
    assign bit_ready  = (r_state == S_HOLD) ? out_ready : 1'b1;
    assign w_bit_xfer = bit_valid & bit_ready;
    assign w_word     = {r_shreg[DATA_W-2:0], bit_in};
    assign out_valid  = (r_state == S_HOLD);
    assign out_data   = r_out_data;
    assign all_set    = r_all_set;
    assign set_count  = r_set_count;
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < DATA_W; i++)
            w_pop = w_pop + CNT_W'(w_word[i]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_cnt       <= '0;
            r_shreg     <= '0;
            r_out_data  <= '0;
            r_all_set   <= 1'b0;
            r_set_count <= '0;
        end else if (r_state == S_FILL) begin
            if (w_bit_xfer) begin
                r_shreg <= w_word;
                if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    r_out_data  <= w_word;
                    r_all_set   <= &w_word;
                    r_set_count <= w_pop;
                    r_cnt       <= '0;
                    r_state     <= S_HOLD;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end else if (out_ready) begin
            // word leaves; a bit arriving now is the next word's MSB, so no bubble
            r_state <= S_FILL;
            r_shreg <= {{(DATA_W-1){1'b0}}, bit_in & bit_valid};
            r_cnt   <= bit_valid ? CNT_W'(1) : '0;
        end
    end
endmodule

// File: tb/tb_serial_all_bits_set_rx.sv
// tb_serial_all_bits_set_rx: directed tests with hand-computed expected words.
module tb_serial_all_bits_set_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       all_set;
    logic [3:0] set_count;
    int checks = 0;
    int errors = 0;

    serial_all_bits_set_rx #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .all_set(all_set), .set_count(set_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in = b;
        step();
        bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (all_set !== 1'b0) begin errors++; $display("FAIL reset_all_set got %b want 0", all_set); end
        if (set_count !== 4'd0) begin errors++; $display("FAIL reset_set_count got %0d want 0", set_count); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        if (bit_ready !== 1'b1) begin errors++; $display("FAIL reset_bit_ready got %b want 1", bit_ready); end
    endtask

    task automatic test_all_ones();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_early_valid got %b want 0", out_valid); end
        send_bit(1'b1);
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_valid got %b want 1", out_valid); end
        if (out_data !== 8'hFF) begin errors++; $display("FAIL ones_data got %h want ff", out_data); end
        if (all_set !== 1'b1) begin errors++; $display("FAIL ones_all_set got %b want 1", all_set); end
        if (set_count !== 4'd8) begin errors++; $display("FAIL ones_count got %0d want 8", set_count); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_valid_pulse got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        stream = 16'hAAFE;
        out_ready = 1'b1;
        bit_valid = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            bit_in = stream[i];
            step();
            if (i == 8) begin
                checks += 4;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_aa_valid got %b want 1", out_valid); end
                if (out_data !== 8'hAA) begin errors++; $display("FAIL b2b_aa_data got %h want aa", out_data); end
                if (all_set !== 1'b0) begin errors++; $display("FAIL b2b_aa_all_set got %b want 0", all_set); end
                if (set_count !== 4'd4) begin errors++; $display("FAIL b2b_aa_count got %0d want 4", set_count); end
            end
            if (i == 7) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap_valid got %b want 0", out_valid); end
            end
        end
        bit_valid = 1'b0;
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_fe_valid got %b want 1", out_valid); end
        if (out_data !== 8'hFE) begin errors++; $display("FAIL b2b_fe_data got %h want fe", out_data); end
        if (all_set !== 1'b0) begin errors++; $display("FAIL b2b_fe_all_set got %b want 0", all_set); end
        if (set_count !== 4'd7) begin errors++; $display("FAIL b2b_fe_count got %0d want 7", set_count); end
        step();
    endtask

    task automatic test_backpressure();
        logic [7:0] w;
        w = 8'hC3;
        out_ready = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", out_valid); end
        bit_valid = 1'b1;
        bit_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks += 4;
            if (bit_ready !== 1'b0) begin errors++; $display("FAIL bp_bit_ready c%0d got %b want 0", c, bit_ready); end
            if (out_data !== 8'hC3) begin errors++; $display("FAIL bp_hold_data c%0d got %h want c3", c, out_data); end
            if (set_count !== 4'd4) begin errors++; $display("FAIL bp_hold_count c%0d got %0d want 4", c, set_count); end
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c%0d got %b want 1", c, out_valid); end
            step();
        end
        out_ready = 1'b1;
        bit_in = 1'b1;
        #1;
        checks++;
        if (bit_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", bit_ready); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_accept_valid got %b want 0", out_valid); end
        bit_in = 1'b0;
        for (int i = 0; i < 7; i++) step();
        bit_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got %b want 1", out_valid); end
        if (out_data !== 8'h80) begin errors++; $display("FAIL bp_next_data got %h want 80", out_data); end
        if (set_count !== 4'd1) begin errors++; $display("FAIL bp_next_count got %0d want 1", set_count); end
        step();
    endtask

    task automatic test_zeros_gaps();
        int gap;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b0);
            if (i < 7) begin
                gap = int'($urandom_range(0, 3));
                bit_in = 1'b1;
                for (int g = 0; g < gap; g++) step();
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL zeros_early_valid bit%0d got %b want 0", i, out_valid); end
            end
        end
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL zeros_valid got %b want 1", out_valid); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL zeros_data got %h want 00", out_data); end
        if (all_set !== 1'b0) begin errors++; $display("FAIL zeros_all_set got %b want 0", all_set); end
        if (set_count !== 4'd0) begin errors++; $display("FAIL zeros_count got %0d want 0", set_count); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early_valid got %b want 0", out_valid); end
        send_bit(1'b1);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid got %b want 1", out_valid); end
        if (out_data !== 8'hFF) begin errors++; $display("FAIL rstmid_data got %h want ff", out_data); end
        if (all_set !== 1'b1) begin errors++; $display("FAIL rstmid_all_set got %b want 1", all_set); end
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rsthold_valid got %b want 0", out_valid); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL rsthold_data got %h want 00", out_data); end
        if (bit_ready !== 1'b1) begin errors++; $display("FAIL rsthold_bit_ready got %b want 1", bit_ready); end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_back_to_back();
        test_backpressure();
        test_zeros_gaps();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
